// File: rtl/pcpu_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the serializer state encoding, the register word offsets inside the
// register window, and a helper that turns a base word index plus an offset
// into an absolute word index for address decode.
package pcpu;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Word offsets relative to the window base (decode is on Addr_in[11:2]).
    localparam logic [9:0] REG_TXDATA = 10'd0;
    localparam logic [9:0] REG_STATUS = 10'd1;

    // Absolute word index of a register, wrapping inside the 10-bit field.
    function automatic logic [9:0] reg_word(input logic [9:0] base_word,
                                            input logic [9:0] ofs);
        return base_word + ofs;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART serializer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i/push_data_i  write request and data
//   pop_i             read request; head is visible on pop_data_o beforehand
//   pop_data_o        current head entry (valid when not empty)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (0..DEPTH)
// A push while full is accepted only if a pop happens in the same cycle, in
// which case the count is unchanged.
module uart_tx_fifo
    import pcpu::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk      single clock, all state on posedge
//   rst      asynchronous active-high reset
//   MemRW    CPU store strobe (one cycle per store)
//   Addr_in  CPU byte address, decoded on bits [11:2] only
//   Data_in  CPU store data; TXDATA uses bits [7:0]
//   rd_data  combinational read data (STATUS only, zero elsewhere)
//   txd      serial line, idle high
//   tx_busy  high while a frame is in START, DATA or STOP
// Registers (word offsets from BASE_ADDR):
//   TXDATA (+0) write pushes a byte; dropped with sticky overflow when full
//   STATUS (+1) read {overflow, full, empty, busy}; any write clears overflow
//
// state    | meaning
// ---------+---------------------------------------------------------
// TX_IDLE  | line high; pops the FIFO head as soon as one is queued
// TX_START | start bit (low) for CLK_DIV cycles
// TX_DATA  | eight data bits, LSB first, CLK_DIV cycles each
// TX_STOP  | stop bit (high) for CLK_DIV cycles, then back to idle
module mmio_uart_tx
    import pcpu::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRW,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] rd_data,
    output logic        txd,
    output logic        tx_busy
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [9:0] TXDATA_IDX = reg_word(BASE_ADDR[11:2], REG_TXDATA);
    localparam logic [9:0] STATUS_IDX = reg_word(BASE_ADDR[11:2], REG_STATUS);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              overflow_q, overflow_d;

    logic                        sel_txdata;
    logic                        sel_status;
    logic                        wr_txdata;
    logic                        wr_status;
    logic                        fifo_pop;
    logic [7:0]                  fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        baud_done;

    assign sel_txdata = (Addr_in[11:2] == TXDATA_IDX);
    assign sel_status = (Addr_in[11:2] == STATUS_IDX);
    assign wr_txdata  = MemRW && sel_txdata;
    assign wr_status  = MemRW && sel_status;

    assign rd_data = sel_status ? {28'b0, overflow_q, fifo_full, fifo_empty, tx_busy}
                                : 32'b0;

    // Address/data bits outside the decode and the byte lane, plus the
    // occupancy count, are intentionally not used here.
    logic unused_bits;
    assign unused_bits = ^{Addr_in[31:12], Addr_in[1:0], Data_in[31:8], fifo_count};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_txdata),
        .push_data_i (Data_in[7:0]),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Overflow only when the write is really dropped: a same-cycle pop
    // frees the slot and the FIFO accepts the byte.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_status) begin
            overflow_d = 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);
    assign tx_busy   = (state_q != TX_IDLE);
    assign txd       = txd_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        txd_d    = 1'b1;
        case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                txd_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                txd_d = 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // txd is registered so the pin never glitches on decode; it trails the
    // state register by one cycle, which keeps every bit exactly CLK_DIV long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
